// File: rtl/pm_fetch_pkg.sv
// Shared constants and fetch FSM encoding for the program-memory fetch queue.
// No logic here; imported by the queue top and its storage FIFO.
package pm_fetch_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INS_W  = 32;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pm_fetch_fifo.sv
// Instruction queue storage: data + pc per entry; push visible at head the cycle after.
// No internal backpressure; clear wins over push/pop, push is dropped only when full with no pop.
module pm_fetch_fifo
  import pm_fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DAT_W = DEF_INS_W,
  parameter int PC_W  = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DAT_W-1:0]         push_dat,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     pop,
  input  logic                     clear,
  output logic [DAT_W-1:0]         head_dat,
  output logic [PC_W-1:0]          head_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DAT_W-1:0] dat_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !clear && (level != '0);
  assign do_push = push && !clear && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Payload needs no reset: the head is masked by the occupancy count upstream.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dat_mem[wr_ptr] <= push_dat;
      pc_mem[wr_ptr]  <= push_pc;
    end
  end

  assign head_dat = dat_mem[rd_ptr];
  assign head_pc  = pc_mem[rd_ptr];

endmodule

// File: rtl/pm_fetch_queue.sv
// Instruction prefetch queue: fetch-to-head latency 2 cycles (issue, response write, head).
// Fetches throttle so queued + in-flight never exceeds DEPTH; redirect flushes and refetches.
module pm_fetch_queue
  import pm_fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INS_W    = DEF_INS_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [INS_W-1:0]       mem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic [INS_W-1:0]       ins,
  output logic [ADDR_W-1:0]      ins_pc,
  output logic [$clog2(DEPTH):0] level
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic              room;
  logic              push;
  logic              pop;
  logic [INS_W-1:0]  head_dat;
  logic [ADDR_W-1:0] head_pc;

  // The response still in flight holds a slot, so the queue can never overflow.
  assign room = (int'(level) + int'(inflight_q)) < DEPTH;

  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     mem_en = room && !redirect;
      FLUSH: begin
        mem_en  = !redirect;
        state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
    if (redirect) state_d = FLUSH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_en;
      if (mem_en) inflight_pc_q <= pc_q;
      if (redirect)    pc_q <= redirect_pc;
      else if (mem_en) pc_q <= pc_q + ADDR_W'(1);
    end
  end

  // Redirect drops the arriving response and any same-cycle pop.
  assign push = inflight_q && !redirect;
  assign pop  = ins_valid && ins_ready && !redirect;

  pm_fetch_fifo #(
    .DEPTH (DEPTH),
    .DAT_W (INS_W),
    .PC_W  (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (mem_rdata),
    .push_pc  (inflight_pc_q),
    .pop      (pop),
    .clear    (redirect),
    .head_dat (head_dat),
    .head_pc  (head_pc),
    .level    (level)
  );

  assign mem_addr  = mem_en ? pc_q : '0;
  assign ins_valid = (level != '0);
  assign ins       = ins_valid ? head_dat : '0;
  assign ins_pc    = ins_valid ? head_pc : '0;

endmodule

// File: tb/tb_pm_fetch_queue.sv
// Bench for pm_fetch_queue: table-driven start-up, hand sequences, and a random run
// checked every cycle against a queue-based reference model.
module tb_pm_fetch_queue;

  localparam int          ADDR_W   = 16;
  localparam int          INS_W    = 32;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef logic [15:0] pc_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [INS_W-1:0]  mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ins_valid;
  logic              ins_ready;
  logic [INS_W-1:0]  ins;
  logic [ADDR_W-1:0] ins_pc;
  logic [2:0]        level;

  pm_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INS_W    (INS_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .level       (level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_f(input pc_t a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered list of queued fetch addresses plus one pending fetch.
  pc_t  mq[$];
  logic m_pend;
  pc_t  m_pend_pc;
  pc_t  m_npc;
  logic m_boot;
  logic m_flush;
  logic cap_en = 1'b0;
  pc_t  cap_addr = '0;

  always @(negedge clk) begin
    logic exp_en;
    if (!reset) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_ins_valid", ins_valid, 0);
      chk("rst_ins", ins, 0);
      chk("rst_ins_pc", ins_pc, 0);
      chk("rst_level", level, 0);
      mq.delete();
      m_pend  = 1'b0;
      m_npc   = RESET_PC;
      m_boot  = 1'b1;
      m_flush = 1'b0;
    end else begin
      if (m_boot || redirect) exp_en = 1'b0;
      else if (m_flush)       exp_en = 1'b1;
      else                    exp_en = (mq.size() + int'(m_pend)) < DEPTH;
      chk("mdl_mem_en", mem_en, exp_en);
      if (exp_en) chk("mdl_mem_addr", mem_addr, m_npc);
      chk("mdl_level", level, mq.size());
      chk("mdl_ins_valid", ins_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("mdl_ins_pc", ins_pc, mq[0]);
        chk("mdl_ins", ins, mem_f(mq[0]));
      end else begin
        chk("mdl_ins_pc_idle", ins_pc, 0);
        chk("mdl_ins_idle", ins, 0);
      end
      if (redirect) begin
        mq.delete();
        m_pend  = 1'b0;
        m_npc   = redirect_pc;
        m_flush = 1'b1;
      end else begin
        if (mq.size() != 0 && ins_ready) void'(mq.pop_front());
        if (m_pend) mq.push_back(m_pend_pc);
        m_pend    = exp_en;
        m_pend_pc = m_npc;
        if (exp_en) m_npc = m_npc + 16'd1;
        m_flush = 1'b0;
      end
      m_boot = 1'b0;
    end
    cap_en   = mem_en;
    cap_addr = mem_addr;
  end

  // Program memory: answers exactly one cycle after the strobe, garbage otherwise.
  always begin
    @(posedge clk);
    #1;
    mem_rdata = cap_en ? mem_f(cap_addr) : $urandom;
  end

  typedef struct {
    logic       rdy;
    logic       en;
    logic [15:0] addr;
    logic       vld;
    logic [15:0] pc;
    logic [2:0] lvl;
  } vec_t;

  vec_t tbl[10];
  pc_t  wrap_exp[4];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0};
    tbl[2] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 3'd0};
    tbl[3] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 3'd1};
    tbl[4] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001, 3'd1};
    tbl[5] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 3'd1};
    tbl[6] = '{1'b0, 1'b1, 16'h0005, 1'b1, 16'h0003, 3'd1};
    tbl[7] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0003, 3'd2};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 3'd3};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 3'd4};
    wrap_exp[0] = 16'hFFFE;
    wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000;
    wrap_exp[3] = 16'h0001;

    reset       = 1'b1;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_rdata   = '0;
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;

    // Start-up fill and saturation.
    for (int i = 0; i < 10; i++) begin
      ins_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].en);
      if (tbl[i].en) chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_ins_valid", i), ins_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_ins_pc", i), ins_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_ins", i), ins, mem_f(tbl[i].pc));
      end
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      next();
    end

    // Long stall then drain.
    repeat (8) next();
    @(negedge clk);
    chk("stall_level", level, 4);
    chk("stall_mem_en", mem_en, 0);
    next();
    ins_ready = 1'b1;
    repeat (12) next();

    // Redirect with a full queue.
    ins_ready = 1'b0;
    repeat (8) next();
    @(negedge clk);
    chk("redir_pre_level", level, 4);
    next();
    redirect = 1'b1; redirect_pc = 16'h0040; ins_ready = 1'b1;
    next();
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_n1_valid", ins_valid, 0);
    chk("redir_n1_mem_en", mem_en, 1);
    chk("redir_n1_mem_addr", mem_addr, 16'h0040);
    next();
    @(negedge clk);
    chk("redir_n2_valid", ins_valid, 0);
    next();
    @(negedge clk);
    chk("redir_n3_valid", ins_valid, 1);
    chk("redir_n3_pc", ins_pc, 16'h0040);
    repeat (4) next();

    // Address wrap.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    next();
    redirect = 1'b0;
    next();
    next();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wrap%0d_valid", k), ins_valid, 1);
      chk($sformatf("wrap%0d_pc", k), ins_pc, wrap_exp[k]);
      next();
    end

    // Back-to-back redirects: the second target wins.
    redirect = 1'b1; redirect_pc = 16'h0010;
    next();
    redirect = 1'b1; redirect_pc = 16'h0020;
    @(negedge clk);
    chk("dbl_n1_mem_en", mem_en, 0);
    next();
    redirect = 1'b0;
    @(negedge clk);
    chk("dbl_n2_mem_en", mem_en, 1);
    chk("dbl_n2_mem_addr", mem_addr, 16'h0020);
    chk("dbl_n2_valid", ins_valid, 0);
    next();
    @(negedge clk);
    chk("dbl_n3_valid", ins_valid, 0);
    next();
    @(negedge clk);
    chk("dbl_n4_valid", ins_valid, 1);
    chk("dbl_n4_pc", ins_pc, 16'h0020);
    next();

    // Random traffic against the model.
    repeat (400) begin
      ins_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                                 : 16'hFFFC + 16'($urandom_range(0, 3));
      next();
    end
    redirect = 1'b0;
    next();

    // Asynchronous reset mid-cycle with three entries queued.
    redirect = 1'b1; redirect_pc = 16'h0100; ins_ready = 1'b0;
    next();
    redirect = 1'b0;
    repeat (4) next();
    @(negedge clk);
    chk("arst_pre_level", level, 3);
    #1 reset = 1'b0;
    #1;
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_ins_valid", ins_valid, 0);
    chk("arst_ins", ins, 0);
    chk("arst_ins_pc", ins_pc, 0);
    chk("arst_level", level, 0);
    repeat (3) next();
    reset = 1'b1; ins_ready = 1'b1;
    @(negedge clk);
    chk("arst_boot_mem_en", mem_en, 0);
    next();
    @(negedge clk);
    chk("arst_run_mem_en", mem_en, 1);
    chk("arst_run_addr0", mem_addr, RESET_PC);
    next();
    @(negedge clk);
    chk("arst_run_addr1", mem_addr, RESET_PC + 16'd1);
    repeat (6) next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pm_fetch_queue.md
PM_FETCH_QUEUE -- requirements
Module: pm_fetch_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, program-counter and memory-address width.
REQ-002 The block SHALL have parameter INS_W, default 32, instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 4, instruction-queue entries; power of two, minimum 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port mem_en, output, 1, program-memory read strobe.
REQ-008 The block SHALL have port mem_addr, output, ADDR_W, program-memory read address.
REQ-009 The block SHALL have port mem_rdata, input, INS_W, program-memory data, valid exactly one cycle after mem_en.
REQ-010 The block SHALL have port redirect, input, 1, jump/branch request; flushes the queue.
REQ-011 The block SHALL have port redirect_pc, input, ADDR_W, jump target, sampled when redirect=1.
REQ-012 The block SHALL have port ins_valid, output, 1, queue head holds a valid instruction.
REQ-013 The block SHALL have port ins_ready, input, 1, consumer accepts head; pop when ins_valid and ins_ready are both 1.
REQ-014 The block SHALL have port ins, output, INS_W, head instruction; all-zero (NOP) whenever ins_valid=0.
REQ-015 The block SHALL have port ins_pc, output, ADDR_W, address of head instruction; zero whenever ins_valid=0.
REQ-016 The block SHALL have port level, output, $clog2(DEPTH)+1, current queue occupancy.

Function
REQ-017 The FSM SHALL have states BOOT, RUN and FLUSH; reset enters BOOT; BOOT goes to RUN after one cycle with no fetch issued.
REQ-018 In RUN, mem_en SHALL be 1 exactly when level + inflight < DEPTH and redirect=0, where inflight is 1 if mem_en was 1 last cycle and the response is not yet written.
REQ-019 Each issued fetch SHALL present mem_addr=pc and post-increment pc by 1 modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 with no error.
REQ-020 A response SHALL be written to the queue tail together with its fetch address in the cycle it arrives, and SHALL be visible at the head no earlier than the next cycle; the block has no bypass path.
REQ-021 A push and a pop in the same cycle SHALL both take effect with level unchanged; the queue SHALL never overflow and no instruction SHALL be lost under any ins_ready pattern.
REQ-022 When redirect=1 in cycle N, the block SHALL:
  - clear the queue, so ins_valid=0 from N+1;
  - load pc with redirect_pc;
  - discard any in-flight response;
  - enter FLUSH for one cycle.
REQ-023 In FLUSH (cycle N+1), the block SHALL issue mem_addr=redirect_pc with mem_en=1, then return to RUN; the first post-redirect instruction SHALL have ins_valid=1 in N+3 with ins_pc=redirect_pc.
REQ-024 A pop coinciding with redirect SHALL be ignored, because redirect has priority, and the consumer SHALL treat that head as flushed.
REQ-025 A redirect during FLUSH SHALL restart the flush using the new target.
REQ-026 Pop SHALL never be issued when ins_valid=0, and ins_ready SHALL be don't-care while ins_valid=0.

Reset
REQ-027 While reset=0, asynchronously:
  - pc=RESET_PC;
  - queue empty, level=0;
  - inflight=0;
  - FSM=BOOT;
  - mem_en=0, mem_addr=0, ins_valid=0, ins=0, ins_pc=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and in-flight instructions; after reset deasserts, the first fetch SHALL be RESET_PC in the second cycle (BOOT, then RUN).

Structure
REQ-029 Package pm_fetch_pkg SHALL hold the FSM state encoding and the default ADDR_W, INS_W and DEPTH constants.
REQ-030 Queue storage SHALL be one sub-module, pm_fetch_fifo (push, pop, clear, level, data+pc payload); the fetch FSM and pc logic SHALL stay in pm_fetch_queue.

Verification
REQ-031 Scenario: hold reset low 5 cycles, release, ins_ready=1 -> mem_addr 0,1,2,... on consecutive cycles from the 2nd cycle; after fill, ins_pc 0,1,2,... one per cycle.
REQ-032 Scenario: ins_ready=0 for 10 cycles -> level saturates at 4, mem_en=0 while full; on ins_ready=1, pcs continue in order with no gap or duplicate.
REQ-033 Scenario: with a full queue, redirect=1, redirect_pc=0x0040 in cycle N -> ins_valid=0 in N+1 and N+2; ins_valid=1 in N+3 with ins_pc=0x0040; no pre-redirect instruction appears afterwards.
REQ-034 Scenario: redirect_pc=0xFFFE, ins_ready=1 -> ins_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 Scenario: reset pulled low asynchronously mid-cycle with 3 entries queued -> all outputs zero immediately, without waiting for a clock edge; restart fetches from RESET_PC.
REQ-036 Scenario: redirect asserted on two consecutive cycles to 0x0010 then 0x0020 -> the first delivered instruction has ins_pc=0x0020.
